instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the initiator side of the byte-addressed instruction memory port. It owns the program counter, drives the 32-bit byte address to the instruction memory, and captures the combinationally returned big-endian 32-bit word into an output register. It presents that register to the decode stage through a valid/ready handshake. It sits between the instruction memory and the decode stage, and accepts branch/jump redirects and halt requests from the core.

## Interface
- `INSTR_MEM_SIZE`, 128: instruction memory size in bytes; power of two, ≥ 8.
- `RESET_PC`, 0: PC value after reset; word-aligned, < `INSTR_MEM_SIZE`.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Instr_Addr`  out  32  byte address to instruction memory; equals current PC.
- `Instruction`  in  32  word returned by memory for `Instr_Addr`, same cycle.
- `out_valid`  out  1  `out_instr`/`out_pc` hold a fetched instruction.
- `out_ready`  in  1  decode accepts the output this cycle.
- `out_instr`  out  32  captured instruction word.
- `out_pc`  out  32  address the word was fetched from.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  32  redirect target.
- `halt`  in  1  level request to stop fetching.
- `fault`  out  1  misaligned/out-of-range redirect trapped (macro only).

## Operation
- State machine: RUN, HALT, FAULT. Reset state is RUN.
- Reset values: PC = `RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0.
- `Instr_Addr` = PC, driven combinationally from the PC register. Bits above log2(`INSTR_MEM_SIZE`) are always 0.
- Output slot is free when `out_valid`=0 or (`out_valid` & `out_ready`).
- RUN, slot free, no redirect: capture `Instruction`→`out_instr` and PC→`out_pc`; set `out_valid`=1; PC ← PC+4.
- Slot not free: hold PC and the output registers unchanged.
- PC wrap: when PC+4 = `INSTR_MEM_SIZE`, PC ← 0.
- Redirect takes priority over everything except reset:
  - PC ← target; `out_valid` ← 0; no capture at that edge.
  - A handshake asserted in the same cycle still counts as accepted.
- Halt:
  - RUN → HALT when `halt`=1. The current output stays valid until accepted; no new capture.
  - HALT → RUN when `halt`=0.
  - Redirect while halted updates PC and stays in HALT.
- Target handling without the macro: target ← `redirect_pc` mod `INSTR_MEM_SIZE` with bits [1:0] cleared.

## Timing
- Sequential fetch: one instruction per cycle while `out_ready`=1.
- First `out_valid` appears the cycle after reset deasserts, carrying the word at `RESET_PC`.
- Redirect at cycle n: `Instr_Addr`=target during n+1; `out_valid`=1 with the target word in n+2.
- Halt at cycle n: no capture at the end of n. After `halt` falls in cycle m, the first capture occurs at the end of m+1.
- `rst` asserted mid-operation clears all state immediately, independent of `clk`.

## Configuration
- `FETCH_ALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0, or `redirect_pc` ≥ `INSTR_MEM_SIZE`, enters FAULT.
  - Entering FAULT sets `fault`=1 and `out_valid`=0, and leaves PC unchanged.
  - FAULT exits only via reset or a legal redirect, which clears `fault` and returns to RUN (or HALT if `halt`=1).
- `FETCH_ALIGN_TRAP_EN` undefined:
  - FAULT state is not built and `fault` is tied to 0.
  - Targets are masked as described under Operation.

## Test plan
- Memory words 0x11111111@0, 0x22222222@4, 0x33333333@8; reset released, `out_ready`=1 → `out_instr` sequence 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; `out_pc` 0, 4, 8.
- `out_ready`=0 for 3 cycles after the first word → `out_valid`=1, `out_instr`=0x11111111 held, `Instr_Addr` stays 4; on release, 0x22222222 follows the next cycle.
- PC reaches 124 → `out_pc`=124, then `out_pc`=0 next (wrap).
- Redirect to 8 while `out_pc`=0 → `out_valid`=0 next cycle, then `out_instr`=0x33333333 with `out_pc`=8.
- `halt`=1 for 4 cycles → no new `out_pc` values; after `halt`=0, fetch resumes at the held PC. `rst` pulse mid-stream → `out_valid`=0 and `Instr_Addr`=0 immediately.
- With `FETCH_ALIGN_TRAP_EN`: redirect to 6 → `fault`=1, `out_valid`=0; redirect to 12 → `fault`=0, word@12 two cycles later. Without the macro: redirect to 0x86 → fetch at 4.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, decode handshake, core control.
// Latency: pure wiring, no state.
// Backpressure: out_ready from decode gates the out_valid/out_instr/out_pc slot.
//
// Signals:
//   Instr_Addr / Instruction        byte address out, same-cycle big-endian word back
//   out_valid / out_ready           decode handshake; out_instr / out_pc are the payload
//   redirect_valid / redirect_pc    one-cycle PC load request from the core
//   halt                            level request to stop fetching
//   fault                           trapped illegal redirect (only when the trap is built)
// master = fetch unit, slave = memory/decode/core side.
interface instr_fetch_if;
  logic [31:0] Instr_Addr;
  logic [31:0] Instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;

  modport master (
    output Instr_Addr, out_valid, out_instr, out_pc, fault,
    input  Instruction, out_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  Instr_Addr, out_valid, out_instr, out_pc, fault,
    output Instruction, out_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads memory combinationally, registers one word for decode.
// Latency: word at PC appears on out_instr one cycle after Instr_Addr shows it; redirect-to-valid is 2 cycles.
// Backpressure: with out_valid=1 and out_ready=0 the PC and output slot hold; halt stops new captures.
//
// Ports: clk, rst (async, active-high); bus (instr_fetch_if.master) carrying the memory port,
// the decode valid/ready slot, redirect_valid/redirect_pc, halt and fault.
// Optional macro FETCH_ALIGN_TRAP_EN: illegal redirect targets enter FAULT and raise fault;
// without it, targets are wrapped to the memory size and word-aligned, and fault is tied to 0.
module instr_fetch #(
  parameter int INSTR_MEM_SIZE = 128,
  parameter int RESET_PC       = 0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int AW = $clog2(INSTR_MEM_SIZE);

  typedef logic [AW-1:0] pc_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } out_t;

`ifdef FETCH_ALIGN_TRAP_EN
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
`else
  typedef enum logic {RUN, HALT} state_t;
`endif

  state_t state_q, state_d;
  pc_t    pc_q, pc_d;
  logic   out_vld_q, out_vld_d;
  out_t   out_q, out_d;
  logic   slot_free;
  logic   accepted;
  state_t run_nxt;

`ifdef FETCH_ALIGN_TRAP_EN
  logic   fault_q, fault_d;
  logic   redirect_bad;

  // Target is illegal if not word-aligned or beyond the memory.
  assign redirect_bad = (|bus.redirect_pc[1:0]) || (|bus.redirect_pc[31:AW]);
`else
  // Masked-target mode only uses the in-range word-address bits.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^{bus.redirect_pc[31:AW], bus.redirect_pc[1:0]};
`endif

  assign slot_free = !out_vld_q || bus.out_ready;
  assign accepted  = out_vld_q && bus.out_ready;
  // RUN/HALT simply tracks the halt level one cycle late; redirects never change it.
  assign run_nxt   = bus.halt ? HALT : RUN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= pc_t'(RESET_PC);
      out_vld_q <= 1'b0;
      out_q     <= '0;
`ifdef FETCH_ALIGN_TRAP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
`ifdef FETCH_ALIGN_TRAP_EN
      fault_q   <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
`ifdef FETCH_ALIGN_TRAP_EN
    fault_d   = fault_q;
`endif

    if (bus.redirect_valid) begin
      // Redirect flushes the slot; a same-cycle handshake is still consumed by decode.
      out_vld_d = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
      if (redirect_bad) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end else begin
        pc_d    = bus.redirect_pc[AW-1:0];
        state_d = run_nxt;
        fault_d = 1'b0;
      end
`else
      pc_d    = {bus.redirect_pc[AW-1:2], 2'b00};
      state_d = run_nxt;
`endif
    end else begin
      case (state_q)
        RUN: begin
          state_d = run_nxt;
          // halt blocks the capture in the very cycle it is raised.
          if (!bus.halt && slot_free) begin
            out_d.instr = bus.Instruction;
            out_d.pc    = {{(32-AW){1'b0}}, pc_q};
            out_vld_d   = 1'b1;
            pc_d        = pc_q + pc_t'(4);  // natural wrap at INSTR_MEM_SIZE
          end else if (accepted) begin
            out_vld_d = 1'b0;
          end
        end
        HALT: begin
          state_d = run_nxt;
          if (accepted) begin
            out_vld_d = 1'b0;
          end
        end
`ifdef FETCH_ALIGN_TRAP_EN
        FAULT: begin
          state_d   = FAULT;
          out_vld_d = 1'b0;
        end
`endif
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.Instr_Addr = {{(32-AW){1'b0}}, pc_q};
  assign bus.out_valid  = out_vld_q;
  assign bus.out_instr  = out_q.instr;
  assign bus.out_pc     = out_q.pc;
`ifdef FETCH_ALIGN_TRAP_EN
  assign bus.fault      = fault_q;
`else
  assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic, every cycle
// compared against a transaction-level model of PC, output slot, halt and fault.
// Drives inputs just after the rising edge and samples outputs 1 time unit after it.
module tb_instr_fetch;
  localparam int MEM_SIZE = 128;
  localparam int RESET_PC = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  instr_fetch_if bus();

  instr_fetch #(
    .INSTR_MEM_SIZE(MEM_SIZE),
    .RESET_PC      (RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_SIZE/4];
  assign bus.Instruction = mem[bus.Instr_Addr[6:2]];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_pc;
  bit          m_vld;
  bit          m_halted;
  bit          m_fault;
  logic [31:0] m_instr;
  logic [31:0] m_opc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_vld    = 1'b0;
    m_instr  = '0;
    m_opc    = '0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
  endtask

  // One clock edge worth of behaviour, from the inputs present at that edge.
  task automatic model_step();
    bit          rdy;
    bit          h;
    logic [31:0] rpc;
    rdy = bus.out_ready;
    h   = bus.halt;
    rpc = bus.redirect_pc;
    if (bus.redirect_valid) begin
      m_vld = 1'b0;
`ifdef FETCH_ALIGN_TRAP_EN
      if ((rpc % 4) != 0 || rpc >= MEM_SIZE) begin
        m_fault = 1'b1;
      end else begin
        m_pc    = int'(rpc);
        m_fault = 1'b0;
      end
`else
      m_pc = int'(rpc % 32'(MEM_SIZE));
      m_pc = m_pc - (m_pc % 4);
`endif
    end else if (!m_fault && !m_halted && !h && (!m_vld || rdy)) begin
      m_instr = mem[m_pc / 4];
      m_opc   = 32'(m_pc);
      m_vld   = 1'b1;
      m_pc    = (m_pc + 4) % MEM_SIZE;
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    m_halted = h;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},  bus.Instr_Addr,       32'(m_pc));
    check({tag, ".valid"}, 32'(bus.out_valid),   32'(m_vld));
    check({tag, ".instr"}, bus.out_instr,        m_instr);
    check({tag, ".pc"},    bus.out_pc,           m_opc);
    check({tag, ".fault"}, 32'(bus.fault),       32'(m_fault));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse between edges; state must clear without a clock.
  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_SIZE/4; i++) mem[i] = $urandom;
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;

    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;

    // Reset values and sequential fetch
    rst_pulse("reset");
    check("reset.addr_const", bus.Instr_Addr, 32'(RESET_PC));
    cycle("seq0");
    check("seq0.word", bus.out_instr, 32'h11111111);
    check("seq0.opc",  bus.out_pc,    32'd0);
    cycle("seq1");
    check("seq1.word", bus.out_instr, 32'h22222222);
    check("seq1.opc",  bus.out_pc,    32'd4);
    cycle("seq2");
    check("seq2.word", bus.out_instr, 32'h33333333);
    check("seq2.opc",  bus.out_pc,    32'd8);

    // Backpressure holds the slot and the PC
    rst_pulse("rst_bp");
    cycle("bp0");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      check("bp_hold.word",  bus.out_instr,        32'h11111111);
      check("bp_hold.addr4", bus.Instr_Addr,       32'd4);
      check("bp_hold.vld",   32'(bus.out_valid),   32'd1);
    end
    bus.out_ready = 1'b1;
    cycle("bp_rel");
    check("bp_rel.word", bus.out_instr, 32'h22222222);

    // PC wrap at the top of memory
    for (int i = 0; i < 40 && m_opc != 32'd124; i++) cycle("to_wrap");
    check("wrap.at124", bus.out_pc, 32'd124);
    cycle("wrap");
    check("wrap.opc0", bus.out_pc, 32'd0);

    // Redirect flushes, target word two cycles later
    rst_pulse("rst_redir");
    cycle("redir_pre");
    check("redir_pre.opc", bus.out_pc, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd8;
    cycle("redir");
    check("redir.vld0",  32'(bus.out_valid), 32'd0);
    check("redir.addr8", bus.Instr_Addr,     32'd8);
    bus.redirect_valid = 1'b0;
    cycle("redir_post");
    check("redir_post.word", bus.out_instr,        32'h33333333);
    check("redir_post.opc",  bus.out_pc,           32'd8);
    check("redir_post.vld",  32'(bus.out_valid),   32'd1);

    // Halt for 4 cycles, then resume at the held PC
    bus.halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle("halt");
      check("halt.opc_held", bus.out_pc, 32'd8);
    end
    bus.halt = 1'b0;
    cycle("unhalt0");
    check("unhalt0.vld0", 32'(bus.out_valid), 32'd0);
    cycle("unhalt1");
    check("unhalt1.opc", bus.out_pc,         32'd12);
    check("unhalt1.vld", 32'(bus.out_valid), 32'd1);

    // Mid-stream reset
    cycle("pre_rst");
    rst_pulse("midrst");
    check("midrst.vld0",  32'(bus.out_valid), 32'd0);
    check("midrst.addr0", bus.Instr_Addr,     32'd0);

    // Target handling
    cycle("tgt0");
`ifdef FETCH_ALIGN_TRAP_EN
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd6;
    cycle("trap");
    check("trap.fault", 32'(bus.fault),     32'd1);
    check("trap.vld0",  32'(bus.out_valid), 32'd0);
    bus.redirect_pc    = 32'd12;
    cycle("untrap");
    check("untrap.fault0", 32'(bus.fault), 32'd0);
    bus.redirect_valid = 1'b0;
    cycle("untrap1");
    check("untrap1.word", bus.out_instr, mem[3]);
    check("untrap1.opc",  bus.out_pc,    32'd12);
`else
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h86;
    cycle("mask");
    check("mask.addr4", bus.Instr_Addr, 32'd4);
    bus.redirect_valid = 1'b0;
    cycle("mask1");
    check("mask1.opc",  bus.out_pc,    32'd4);
    check("mask1.word", bus.out_instr, 32'h22222222);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       bus.redirect_pc = 32'($urandom_range(0, 31) * 4);
        1:       bus.redirect_pc = 32'($urandom_range(0, 255));
        default: bus.redirect_pc = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) bus.halt = ~bus.halt;
      if ($urandom_range(0, 99) == 0) rst_pulse("rand_rst");
      else                            cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
